// File: rtl/dp_scan_pkg.sv
// dp_scan_pkg: shared select codes, default depths and step encoding for the display pointer
package dp_scan_pkg;
  localparam int SEL_GR = 0;
  localparam int SEL_MEM = 1;
  localparam int GR_SIZE = 8;
  localparam int MEM_SIZE = 256;
  localparam int DATA_WIDTH_DEF = 16;
  typedef enum logic [1:0] {STEP_NONE, STEP_UP, STEP_DOWN} step_t;
endpackage

// File: rtl/dp_edge_sync.sv
// dp_edge_sync: 2-flop synchroniser for a button level followed by a one-cycle rising-edge pulse
module dp_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);
  logic [2:0] sync;
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= '0;
    else sync <= {sync[1:0], level};
  assign pulse = sync[1] & ~sync[2];
endmodule

// File: rtl/dp_scan.sv
// dp_scan: front-panel display pointer stepping across selectable debug read sources
module dp_scan
  import dp_scan_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_SRC = 2,
  parameter int SEL_WIDTH = 1,
  parameter logic [NUM_SRC*(ADDR_WIDTH+1)-1:0] SRC_DEPTH = {9'(MEM_SIZE), 9'(GR_SIZE)},
  parameter int SCAN_PERIOD = 50_000_000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          stepUp,
  input  logic                          stepDown,
  input  logic                          autoScan,
  input  logic [SEL_WIDTH-1:0]          select,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] srcData,
  output logic [ADDR_WIDTH-1:0]         address,
  output logic [DATA_WIDTH-1:0]         data,
  output logic                          displayEnable
);
  localparam int NSEL = 2**SEL_WIDTH;
  localparam int CW = $clog2(SCAN_PERIOD);
  localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;
  localparam logic [ADDR_WIDTH:0] D_ONE = 1;
  localparam logic [CW-1:0] C_ONE = 1;
  localparam logic [CW-1:0] C_LAST = CW'(SCAN_PERIOD - 1);
  logic [ADDR_WIDTH:0] depths [NSEL];
  logic [DATA_WIDTH-1:0] words [NSEL];
  logic [ADDR_WIDTH:0] depth, depth_m1;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [SEL_WIDTH-1:0] sel_q;
  logic [CW-1:0] cnt;
  logic up_p, dn_p, chg, tc, valid, in_range;
  step_t step;
  dp_edge_sync u_up (.clk(clock), .rst(reset), .level(stepUp), .pulse(up_p));
  dp_edge_sync u_dn (.clk(clock), .rst(reset), .level(stepDown), .pulse(dn_p));
  // select codes without a source read as depth 0, which marks them invalid
  for (genvar i = 0; i < NSEL; i++) begin : g_src
    if (i < NUM_SRC) begin : g_on
      assign depths[i] = SRC_DEPTH[i*(ADDR_WIDTH+1) +: ADDR_WIDTH+1];
      assign words[i] = srcData[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_off
      assign depths[i] = '0;
      assign words[i] = '0;
    end
  end
  always_comb begin
    depth = depths[select];
    depth_m1 = depth - D_ONE;
    valid = depth != '0;
    in_range = valid && ({1'b0, address} < depth);
    chg = select != sel_q;
    tc = autoScan && (cnt == C_LAST);
    step = (up_p || dn_p) ? ((up_p == dn_p) ? STEP_NONE : up_p ? STEP_UP : STEP_DOWN) : tc ? STEP_UP : STEP_NONE;
    addr_nxt = (chg || !valid) ? '0 :
               (step == STEP_UP) ? (({1'b0, address} == depth_m1) ? '0 : address + A_ONE) :
               (step == STEP_DOWN) ? ((address == '0) ? depth_m1[ADDR_WIDTH-1:0] : address - A_ONE) :
               address;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      address <= '0;
      data <= '0;
      displayEnable <= 1'b0;
      cnt <= '0;
      sel_q <= '0;
    end else begin
      address <= addr_nxt;
      data <= in_range ? words[select] : '0;
      displayEnable <= in_range;
      sel_q <= select;
      cnt <= (!autoScan || chg || tc) ? '0 : cnt + C_ONE;
    end
endmodule
